sie_rx_demux: RTL
=================

// Module: sie_rx_demux
// PURPOSE
//  Return path of the USB host/slave SIE sharing: receives bytes from the single SIE receiver and
//  routes each packet to the host or the slave controller, depending on hostMode.
//  hostMode is sampled at packet start. A shared FIFO with per-entry owner tag absorbs backpressure.
//  Overflowed packets are truncated and terminated with an error marker.
//  Sits in the usbClk domain beside the host/slave TX mux.
// PARAMETERS
//  FIFO_DEPTH  4   entries; power of two, >=2
//  DATA_W      8   byte width
//  DROP_CNT_W  16  width of dropped-byte counter
// PORTS
//  usbClk          in  1       sole clock
//  rstSyncToUsbClk in  1       synchronous, active-high reset
//  hostMode        in  1       1=route new packets to host, 0=slave
//  SIERxData       in  DATA_W  received byte
//  SIERxValid      in  1       byte strobe, one cycle per byte, no backpressure
//  SIERxLast       in  1       qualifies SIERxValid: final byte of packet
//  hostRxData      out DATA_W  head byte (host side)
//  hostRxValid     out 1       head entry owned by host
//  hostRxLast      out 1       head is packet end
//  hostRxErr       out 1       head is abort terminator (data=0)
//  hostRxReady     in  1       host pops head when hostRxValid&hostRxReady
//  slaveRxData/Valid/Last/Err out, slaveRxReady in: same as host side
//  rxBusy          out 1       packet in progress or FIFO non-empty
//  rxDropCount     out DROP_CNT_W  dropped bytes, saturating
// BEHAVIOUR
//  Reset: FIFO empty, state IDLE, owner=0, all Valid/Last/Err=0, Data=0, rxBusy=0, rxDropCount=0.
//  FIFO entry = {owner,err,last,data}.
//  Head drives exactly one side: host if owner=1, else slave. The other side Valid=0, Data=0.
//  Outputs are combinational from registered head. Byte pushed in cycle N is visible at N+1 if FIFO was empty.
//  Push when SIERxValid & space. Space = count<FIFO_DEPTH, or a pop occurs in the same cycle.
//  FSM:
//   IDLE: on SIERxValid latch owner<=hostMode, push byte.
//     Last=1 -> stay IDLE (1-byte packet). Else -> PKT.
//     No space -> drop byte and go to DISCARD (or TERM if Last).
//   PKT: push bytes with latched owner; hostMode changes are ignored.
//     Push with Last -> IDLE. No space -> drop byte; Last ? TERM : DISCARD.
//   DISCARD: drop every byte; on Last -> TERM.
//   TERM: push {owner,err=1,last=1,data=0} when space -> IDLE.
//     SIERxValid bytes arriving in TERM are dropped. Those starting a new packet also force their packet to DISCARD after TERM.
//  Every dropped byte increments rxDropCount, saturating at all-ones.
//  Ready on the non-owner side is ignored.
//  Reset mid-packet: FIFO flushed, state IDLE; the next byte is treated as a packet start.
// CONFIGURATION
//  SIE_RX_DROP_CNT_EN defined: rxDropCount counter implemented as above.
//  SIE_RX_DROP_CNT_EN undefined: no counter; rxDropCount tied to 0. Routing unchanged.
// STRUCTURE
//  usb_sie_pkg: rx FSM state localparams (IDLE, PKT, DISCARD, TERM), OWNER_HOST=1, OWNER_SLAVE=0.
//  usb_sie_pkg also holds entry field offsets.
//  Sub-module sie_rx_fifo: sync FIFO, parameter width/depth, push/pop/full/empty/count.
//  Top holds the FSM, owner latch, output steering and drop counter.
// TESTING
//  1. hostMode=1, 3-byte pkt A1,A2,A3(Last), hostRxReady=1
//     -> host sees A1..A3, Last on A3; slaveRxValid stays 0.
//  2. hostMode toggles 1->0 after byte 1 of 4-byte pkt -> all 4 bytes go to host.
//     Next pkt goes to slave.
//  3. FIFO_DEPTH=4, slaveRxReady=0, 6-byte pkt to slave -> 4 bytes queued, 2 dropped.
//     Ready=1 then yields 4 bytes plus terminator {err=1,last=1,data=00}; rxDropCount=2.
//  4. Host pkt queued with host not ready, then slave pkt arrives
//     -> FIFO order kept; slave side waits until host drains.
//  5. Single-byte pkt 5A with Valid&Last in IDLE -> one entry, Last=1; FSM stays IDLE.
//  6. Reset asserted in PKT with 2 entries queued -> next cycle both Valid=0, rxBusy=0.
//     Build without SIE_RX_DROP_CNT_EN: rxDropCount=0 after scenario 3.

Source files
------------

// File: rtl/usb_sie_pkg.sv
// Shared definitions for the SIE receive return path: rx FSM states, owner tags and
// FIFO entry field offsets. An entry is {owner, err, last, data}, with data in the low bits.
package usb_sie_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PKT     = 2'd1,
    DISCARD = 2'd2,
    TERM    = 2'd3
  } rxState_t;

  localparam logic OWNER_HOST  = 1'b1;
  localparam logic OWNER_SLAVE = 1'b0;

  // Control bit offsets, counted upward from the top of the data field
  localparam int unsigned ENTRY_LAST_OFS  = 0;
  localparam int unsigned ENTRY_ERR_OFS   = 1;
  localparam int unsigned ENTRY_OWNER_OFS = 2;
  localparam int unsigned ENTRY_CTRL_W    = 3;

endpackage

// File: rtl/sie_rx_fifo.sv
// Synchronous FIFO holding tagged receive entries. DEPTH must be a power of two so the
// pointers wrap naturally. A push while full is accepted only when a pop frees a slot.
module sie_rx_fifo #(
  parameter int unsigned WIDTH = 11,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           pushData,
  input  logic                       pop,
  output logic [WIDTH-1:0]           popData,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PtrW-1:0]  wrPtr;
  logic [PtrW-1:0]  rdPtr;
  logic [CntW-1:0]  cnt;
  logic             doPush;
  logic             doPop;

  assign full    = (cnt == CntW'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign popData = mem[rdPtr];
  assign doPop   = pop & ~empty;
  assign doPush  = push & (~full | doPop);

  // Storage array, written without reset; empty entries are never presented as valid
  always_ff @(posedge clk) begin
    if (doPush) begin
      mem[wrPtr] <= pushData;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      cnt   <= '0;
    end else begin
      if (doPush) begin
        wrPtr <= wrPtr + 1'b1;
      end
      if (doPop) begin
        rdPtr <= rdPtr + 1'b1;
      end
      if (doPush && !doPop) begin
        cnt <= cnt + 1'b1;
      end else if (doPop && !doPush) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/sie_rx_demux.sv
// Routes bytes from the shared SIE receiver to the host or slave controller. The owner is
// sampled from hostMode at packet start and tagged onto every FIFO entry, so queued packets
// keep their destination even if the mode flips. Packets that overflow the FIFO are cut short
// and closed with an error terminator entry (err=1, last=1, data=0).
// Build option: define SIE_RX_DROP_CNT_EN to implement the saturating rxDropCount counter;
// otherwise rxDropCount is tied to zero.
module sie_rx_demux
  import usb_sie_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned DROP_CNT_W = 16
) (
  input  logic                  usbClk,
  input  logic                  rstSyncToUsbClk,
  input  logic                  hostMode,
  input  logic [DATA_W-1:0]     SIERxData,
  input  logic                  SIERxValid,
  input  logic                  SIERxLast,
  output logic [DATA_W-1:0]     hostRxData,
  output logic                  hostRxValid,
  output logic                  hostRxLast,
  output logic                  hostRxErr,
  input  logic                  hostRxReady,
  output logic [DATA_W-1:0]     slaveRxData,
  output logic                  slaveRxValid,
  output logic                  slaveRxLast,
  output logic                  slaveRxErr,
  input  logic                  slaveRxReady,
  output logic                  rxBusy,
  output logic [DROP_CNT_W-1:0] rxDropCount
);

  localparam int unsigned EntryW = DATA_W + ENTRY_CTRL_W;
  localparam int unsigned CountW = $clog2(FIFO_DEPTH + 1);

  rxState_t          state;
  logic              owner;
  logic              newPktOpen;
  logic              newOwner;
  logic              termOpen;
  logic              termOwner;
  logic              push;
  logic              pop;
  logic              drop;
  logic              space;
  logic              full;
  logic              empty;
  logic [CountW-1:0] fifoCount;
  logic [EntryW-1:0] pushEntry;
  logic [EntryW-1:0] headEntry;
  logic              headOwner;
  logic              hostSel;
  logic              slaveSel;

  sie_rx_fifo #(
    .WIDTH (EntryW),
    .DEPTH (FIFO_DEPTH)
  ) uFifo (
    .clk      (usbClk),
    .rst      (rstSyncToUsbClk),
    .push     (push),
    .pushData (pushEntry),
    .pop      (pop),
    .popData  (headEntry),
    .full     (full),
    .empty    (empty),
    .count    (fifoCount)
  );

  assign headOwner = headEntry[DATA_W + ENTRY_OWNER_OFS];
  assign hostSel   = ~empty & (headOwner == OWNER_HOST);
  assign slaveSel  = ~empty & (headOwner == OWNER_SLAVE);
  // Ready from the side that does not own the head is ignored
  assign pop       = (hostSel & hostRxReady) | (slaveSel & slaveRxReady);
  assign space     = ~full | pop;

  // Output steering: only the owning side sees the head, the other side reads all zeros
  always_comb begin
    hostRxValid  = hostSel;
    hostRxData   = hostSel ? headEntry[DATA_W-1:0] : '0;
    hostRxLast   = hostSel & headEntry[DATA_W + ENTRY_LAST_OFS];
    hostRxErr    = hostSel & headEntry[DATA_W + ENTRY_ERR_OFS];
    slaveRxValid = slaveSel;
    slaveRxData  = slaveSel ? headEntry[DATA_W-1:0] : '0;
    slaveRxLast  = slaveSel & headEntry[DATA_W + ENTRY_LAST_OFS];
    slaveRxErr   = slaveSel & headEntry[DATA_W + ENTRY_ERR_OFS];
  end

  assign rxBusy = (state != IDLE) || (fifoCount != '0);

  // Push/drop decision and entry assembly for the current state
  always_comb begin
    push      = 1'b0;
    drop      = 1'b0;
    pushEntry = '0;
    pushEntry[DATA_W-1:0]              = SIERxData;
    pushEntry[DATA_W + ENTRY_LAST_OFS]  = SIERxLast;
    pushEntry[DATA_W + ENTRY_OWNER_OFS] = owner;
    // A packet starting while the terminator waits is tracked so it can be discarded later
    termOpen  = newPktOpen;
    termOwner = newOwner;
    unique case (state)
      IDLE: begin
        pushEntry[DATA_W + ENTRY_OWNER_OFS] = hostMode;
        push = SIERxValid & space;
        drop = SIERxValid & ~space;
      end
      PKT: begin
        push = SIERxValid & space;
        drop = SIERxValid & ~space;
      end
      DISCARD: begin
        drop = SIERxValid;
      end
      TERM: begin
        pushEntry = '0;
        pushEntry[DATA_W + ENTRY_LAST_OFS]  = 1'b1;
        pushEntry[DATA_W + ENTRY_ERR_OFS]   = 1'b1;
        pushEntry[DATA_W + ENTRY_OWNER_OFS] = owner;
        push = space;
        drop = SIERxValid;
        if (SIERxValid) begin
          if (!newPktOpen && !SIERxLast) begin
            termOpen  = 1'b1;
            termOwner = hostMode;
          end else if (newPktOpen && SIERxLast) begin
            termOpen = 1'b0;
          end
        end
      end
      default: ;
    endcase
  end

  // Receive FSM with owner latch
  always_ff @(posedge usbClk) begin
    if (rstSyncToUsbClk) begin
      state      <= IDLE;
      owner      <= OWNER_SLAVE;
      newPktOpen <= 1'b0;
      newOwner   <= OWNER_SLAVE;
    end else begin
      unique case (state)
        IDLE: begin
          if (SIERxValid) begin
            owner <= hostMode;
            if (space) begin
              state <= SIERxLast ? IDLE : PKT;
            end else begin
              state <= SIERxLast ? TERM : DISCARD;
            end
          end
        end
        PKT: begin
          if (SIERxValid) begin
            if (!space) begin
              state <= SIERxLast ? TERM : DISCARD;
            end else if (SIERxLast) begin
              state <= IDLE;
            end
          end
        end
        DISCARD: begin
          if (SIERxValid && SIERxLast) begin
            state <= TERM;
          end
        end
        TERM: begin
          if (space) begin
            state      <= termOpen ? DISCARD : IDLE;
            newPktOpen <= 1'b0;
            if (termOpen) begin
              owner <= termOwner;
            end
          end else begin
            newPktOpen <= termOpen;
            newOwner   <= termOwner;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SIE_RX_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] dropCount;

  // Saturating count of bytes that never reached the FIFO
  always_ff @(posedge usbClk) begin
    if (rstSyncToUsbClk) begin
      dropCount <= '0;
    end else if (drop && (dropCount != '1)) begin
      dropCount <= dropCount + 1'b1;
    end
  end

  assign rxDropCount = dropCount;
`else
  logic unusedDrop;
  assign unusedDrop  = drop;
  assign rxDropCount = '0;
`endif

endmodule
